// File: rtl/rca_16_bit.sv
// 16-bit unsigned ripple-carry adder built from a chain of full-adder cells,
// with the sum and carry-out registered once on the output.
module rca_16_bit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_in_i,
  output logic [WIDTH-1:0] s_o,
  output logic             c_out_o
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  logic [WIDTH-1:0] s_q, s_d;
  logic             c_out_q, c_out_d;

  assign carry[0] = c_in_i;

  // One full-adder cell per bit; carry[i+1] feeds cell i+1.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa_cell
    logic prop;
    assign prop       = a_i[i] ^ b_i[i];
    assign sum[i]     = prop ^ carry[i];
    assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & prop);
  end

  always_comb begin
    s_d     = sum;
    c_out_d = carry[WIDTH];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_q     <= '0;
      c_out_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      c_out_q <= c_out_d;
    end
  end

  assign s_o     = s_q;
  assign c_out_o = c_out_q;

endmodule

// File: tb/tb_rca_16_bit.sv
// Directed vector bench for rca_16_bit: table of hand-computed results plus
// reset hold/discard/recovery sequences.
module tb_rca_16_bit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] a_i, b_i;
  logic        c_in_i;
  logic [15:0] s_o;
  logic        c_out_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] s;
    logic        co;
  } vec_t;

  localparam int NumVec = 12;
  vec_t vecs [NumVec];

  rca_16_bit #(.WIDTH(16)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .c_in_i  (c_in_i),
    .s_o     (s_o),
    .c_out_o (c_out_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [15:0] s_exp, input logic c_exp);
    checks++;
    if (s_o !== s_exp || c_out_o !== c_exp) begin
      errors++;
      $display("FAIL %s: got s=%0d c_out=%0b, expected s=%0d c_out=%0b",
               name, s_o, c_out_o, s_exp, c_exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic ci);
    a_i    = a;
    b_i    = b;
    c_in_i = ci;
  endtask

  initial begin
    //           a         b         ci    s         co
    vecs[0]  = {16'd1076,  16'd13875, 1'b1, 16'd14952, 1'b0};
    vecs[1]  = {16'd31245, 16'd7785,  1'b0, 16'd39030, 1'b0};
    vecs[2]  = {16'd25000, 16'd25600, 1'b1, 16'd50601, 1'b0};
    vecs[3]  = {16'd25001, 16'd40535, 1'b1, 16'd1,     1'b1};
    vecs[4]  = {16'd25080, 16'd40535, 1'b0, 16'd79,    1'b1};
    vecs[5]  = {16'hFFFF,  16'h0000,  1'b1, 16'h0000,  1'b1};
    vecs[6]  = {16'hFFFF,  16'hFFFF,  1'b1, 16'hFFFF,  1'b1};
    vecs[7]  = {16'h0000,  16'h0000,  1'b0, 16'h0000,  1'b0};
    vecs[8]  = {16'h8000,  16'h8000,  1'b0, 16'h0000,  1'b1};
    vecs[9]  = {16'hAAAA,  16'h5555,  1'b0, 16'hFFFF,  1'b0};
    vecs[10] = {16'hAAAA,  16'h5555,  1'b1, 16'h0000,  1'b1};
    vecs[11] = {16'h1234,  16'h4321,  1'b0, 16'h5555,  1'b0};

    rst_i = 1'b1;
    drive(16'd1234, 16'd4321, 1'b1);
    repeat (2) @(posedge clk_i);
    #1 check("reset_state", 16'h0000, 1'b0);

    @(negedge clk_i);
    rst_i = 1'b0;

    // Back-to-back vectors, one per cycle, each checked after its sampling edge.
    for (int i = 0; i < NumVec; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].ci);
      @(posedge clk_i);
      #1 check($sformatf("vec%0d", i), vecs[i].s, vecs[i].co);
      @(negedge clk_i);
    end

    // Reset is synchronous: outputs hold until the edge, then clear.
    drive(16'd25080, 16'd40535, 1'b0);
    @(posedge clk_i);
    #1 check("pre_reset", 16'd79, 1'b1);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1 check("reset_hold_before_edge", 16'd79, 1'b1);
    @(posedge clk_i);
    #1 check("reset_clears", 16'h0000, 1'b0);

    // Operation sampled while reset is high is discarded.
    @(negedge clk_i);
    drive(16'hFFFF, 16'h0000, 1'b1);
    @(posedge clk_i);
    #1 check("reset_discards_op", 16'h0000, 1'b0);

    // First valid result one cycle after deassert.
    @(negedge clk_i);
    rst_i = 1'b0;
    #1 check("deassert_before_edge", 16'h0000, 1'b0);
    @(posedge clk_i);
    #1 check("recover_after_reset", 16'h0000, 1'b1);

    @(negedge clk_i);
    drive(16'd1076, 16'd13875, 1'b1);
    @(posedge clk_i);
    #1 check("post_reset_vec", 16'd14952, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
